// File: rtl/pipeline_hazard_ctrl.sv
// EX-stage operand scheduler for a 5-stage MIPS pipeline.
// Shadows the destination registers of in-flight instructions in EX/MEM/WB
// slots, produces registered forward selects for the ALU operand muxes, and
// raises a one-cycle stall plus bubble on load-use hazards. flush kills the
// ID instruction, hold freezes everything, and stall_cnt counts stall cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic [REG_W-1:0] ID_dst,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic [REG_W-1:0] dst;
  } slot_t;

  // Forward select encodings seen by the EX operand muxes.
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  slot_t ex_reg;
  slot_t mem_reg;
  // The register file is write-before-read, so the WB slot is bookkeeping
  // only: it mirrors the pipeline but no forwarding decision reads it.
  slot_t wb_slot_unused_reg;

  slot_t id_slot;
  logic  ex_writer;
  logic  mem_writer;
  logic  hazard;

  // Operand 0 is the ALU A path (rs), operand 1 the ALU B path (rt).
  logic [1:0][REG_W-1:0] op_src;
  logic [1:0]            op_use;
  logic [1:0]            ex_match;
  logic [1:0]            mem_match;
  logic [1:0]            op_hazard;
  logic [1:0][1:0]       fwd_next;

  assign id_slot = {ID_valid, ID_RegWrite, ID_MemRead, ID_dst};
  assign op_src  = {ID_rt, ID_rs};
  assign op_use  = {ID_use_rt, ID_use_rs};

  // A slot writing $0 is never a producer, so $0 can never match below.
  assign ex_writer  = ex_reg.valid && ex_reg.reg_write && (ex_reg.dst != '0);
  assign mem_writer = mem_reg.valid && mem_reg.reg_write && (mem_reg.dst != '0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign ex_match[gi]  = op_use[gi] && ex_writer && (ex_reg.dst == op_src[gi]);
    assign mem_match[gi] = op_use[gi] && mem_writer && (mem_reg.dst == op_src[gi]);
    // A load in EX has no data yet, so a match there is a hazard, not a forward.
    assign op_hazard[gi] = ex_match[gi] && ex_reg.mem_read;
    // The younger producer (EX) wins over the older one (MEM).
    assign fwd_next[gi]  = (ex_match[gi] && !ex_reg.mem_read) ? FWD_EXMEM :
                           mem_match[gi]                      ? FWD_MEMWB :
                                                                FWD_NONE;
  end

  assign hazard = ID_valid && (|op_hazard);
  // flush supersedes a stall; hold freezes the pipe so neither takes effect.
  assign stall  = hazard && !flush && !hold;
  assign bubble = (stall || flush) && !hold;

  // Advance the shadow slots and register the forward selects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_reg             <= '0;
      mem_reg            <= '0;
      wb_slot_unused_reg <= '0;
      ForwardA           <= FWD_NONE;
      ForwardB           <= FWD_NONE;
      stall_cnt          <= '0;
    end else if (!hold) begin
      wb_slot_unused_reg <= mem_reg;
      mem_reg            <= ex_reg;
      if (bubble) begin
        ex_reg   <= '0;
        ForwardA <= FWD_NONE;
        ForwardB <= FWD_NONE;
      end else begin
        ex_reg   <= id_slot;
        ForwardA <= fwd_next[0];
        ForwardB <= fwd_next[1];
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations followed by random traffic, all checked every cycle against
// a history-queue model of the instructions in flight.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;  // narrow counter so saturation is reachable

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ID_valid = 1'b0;
  logic [REG_W-1:0] ID_rs = '0;
  logic [REG_W-1:0] ID_rt = '0;
  logic             ID_use_rs = 1'b0;
  logic             ID_use_rt = 1'b0;
  logic             ID_RegWrite = 1'b0;
  logic             ID_MemRead = 1'b0;
  logic [REG_W-1:0] ID_dst = '0;
  logic             flush = 1'b0;
  logic             hold = 1'b0;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_dst(ID_dst),
    .flush(flush), .hold(hold),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[0] is the instruction now in EX, hist[1] the one in MEM, hist[2] WB.
  typedef struct packed {
    logic             v;
    logic             rw;
    logic             mr;
    logic [REG_W-1:0] dst;
  } ins_t;

  ins_t       hist[$];
  logic [1:0] m_fa;
  logic [1:0] m_fb;
  int         m_cnt;

  function automatic bit writes(ins_t i, logic [REG_W-1:0] r);
    return i.v && i.rw && (i.dst != 0) && (i.dst == r);
  endfunction

  function automatic logic [1:0] model_sel(logic u, logic [REG_W-1:0] r);
    if (!u) return 2'b00;
    if (writes(hist[0], r) && !hist[0].mr) return 2'b10;
    if (writes(hist[1], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit model_hazard();
    if (!ID_valid || !hist[0].mr) return 1'b0;
    return (ID_use_rs && writes(hist[0], ID_rs)) || (ID_use_rt && writes(hist[0], ID_rt));
  endfunction

  task automatic model_clear();
    hist.delete();
    repeat (3) hist.push_back('0);
    m_fa  = 2'b00;
    m_fb  = 2'b00;
    m_cnt = 0;
  endtask

  // Compare on the falling edge (inputs stable), then advance the model to
  // what the coming rising edge must produce.
  always @(negedge clk) begin : compare
    bit         e_stall;
    bit         e_bubble;
    ins_t       nx;
    logic [1:0] na;
    logic [1:0] nb;
    if (!reset) model_clear();
    e_stall  = model_hazard() && !flush && !hold;
    e_bubble = (e_stall || flush) && !hold;
    chk("stall",     32'(stall),     32'(e_stall));
    chk("bubble",    32'(bubble),    32'(e_bubble));
    chk("ForwardA",  32'(ForwardA),  32'(m_fa));
    chk("ForwardB",  32'(ForwardB),  32'(m_fb));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (reset && !hold) begin
      na = model_sel(ID_use_rs, ID_rs);
      nb = model_sel(ID_use_rt, ID_rt);
      nx = e_bubble ? ins_t'(0) : '{v: ID_valid, rw: ID_RegWrite, mr: ID_MemRead, dst: ID_dst};
      hist.push_front(nx);
      void'(hist.pop_back());
      m_fa = e_bubble ? 2'b00 : na;
      m_fb = e_bubble ? 2'b00 : nb;
      if (e_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_id(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic urs, input logic urt, input logic rw, input logic mr,
                        input logic [REG_W-1:0] dst);
    ID_valid = v; ID_rs = rs; ID_rt = rt; ID_use_rs = urs; ID_use_rt = urt;
    ID_RegWrite = rw; ID_MemRead = mr; ID_dst = dst;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bubble", 32'(bubble), 0);
    chk("rst_fa", 32'(ForwardA), 0);
    chk("rst_fb", 32'(ForwardB), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    tick();
    reset = 1'b1;

    // back-to-back: add $3<-$1,$2 ; sub $4<-$3,$5
    set_id(1, 1, 2, 1, 1, 1, 0, 3); tick();
    set_id(1, 3, 5, 1, 1, 1, 0, 4); #1;
    chk("b2b_stall", 32'(stall), 0);
    tick();
    chk("b2b_fa", 32'(ForwardA), 32'b10);
    chk("b2b_fb", 32'(ForwardB), 32'b00);

    // distance 2: add $3 ; nop ; or $6<-$7,$3
    set_id(1, 1, 2, 1, 1, 1, 0, 3); tick();
    nop(); tick();
    set_id(1, 7, 3, 1, 1, 1, 0, 6); tick();
    chk("d2_fa", 32'(ForwardA), 32'b00);
    chk("d2_fb", 32'(ForwardB), 32'b01);
    // $3 written in both EX and MEM: EX wins
    set_id(1, 1, 2, 1, 1, 1, 0, 3); tick();
    set_id(1, 4, 4, 1, 1, 1, 0, 3); tick();
    set_id(1, 3, 0, 1, 0, 1, 0, 10); tick();
    chk("prio_fa", 32'(ForwardA), 32'b10);
    chk("prio_fb", 32'(ForwardB), 32'b00);

    // load-use: lw $8 ; add $9<-$8,$8
    set_id(1, 1, 0, 1, 0, 1, 1, 8); tick();
    set_id(1, 8, 8, 1, 1, 1, 0, 9); #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_bubble", 32'(bubble), 1);
    tick();
    chk("lu_stall_once", 32'(stall), 0);
    chk("lu_cnt", 32'(stall_cnt), 1);
    tick();
    chk("lu_fa", 32'(ForwardA), 32'b01);
    chk("lu_fb", 32'(ForwardB), 32'b01);

    // $0 never forwarded nor stalled on
    set_id(1, 1, 2, 1, 1, 1, 0, 0); tick();
    set_id(1, 0, 0, 1, 1, 1, 0, 5); #1;
    chk("r0_stall", 32'(stall), 0);
    tick();
    chk("r0_fa", 32'(ForwardA), 0);
    chk("r0_fb", 32'(ForwardB), 0);
    set_id(1, 1, 0, 1, 0, 1, 1, 0); tick();
    set_id(1, 0, 0, 1, 1, 1, 0, 6); #1;
    chk("r0_load_stall", 32'(stall), 0);
    tick();
    // sll (shamt, use_rs = 0) after writer of its rs
    set_id(1, 1, 2, 1, 1, 1, 0, 5); tick();
    set_id(1, 5, 2, 0, 1, 1, 0, 7); tick();
    chk("sll_fa", 32'(ForwardA), 0);

    // flush during load-use
    set_id(1, 1, 0, 1, 0, 1, 1, 8); tick();
    set_id(1, 8, 8, 1, 1, 1, 0, 9); flush = 1'b1; #1;
    chk("fl_stall", 32'(stall), 0);
    chk("fl_bubble", 32'(bubble), 1);
    tick();
    flush = 1'b0;
    chk("fl_cnt", 32'(stall_cnt), 1);
    chk("fl_fa", 32'(ForwardA), 0);
    nop(); tick();

    // hold for 3 cycles over a pending load-use
    set_id(1, 2, 3, 1, 1, 1, 0, 1); tick();
    set_id(1, 1, 0, 1, 0, 1, 1, 8); tick();
    chk("hd_pre_fa", 32'(ForwardA), 32'b10);
    set_id(1, 8, 0, 1, 0, 1, 0, 9); hold = 1'b1; #1;
    chk("hd_stall", 32'(stall), 0);
    chk("hd_bubble", 32'(bubble), 0);
    repeat (3) begin
      tick();
      chk("hd_frz_fa", 32'(ForwardA), 32'b10);
      chk("hd_frz_cnt", 32'(stall_cnt), 1);
      chk("hd_frz_stall", 32'(stall), 0);
    end
    hold = 1'b0; #1;
    chk("hd_rel_stall", 32'(stall), 1);
    tick(); tick();
    chk("hd_rel_fa", 32'(ForwardA), 32'b01);
    chk("hd_rel_cnt", 32'(stall_cnt), 2);

    // asynchronous reset in the middle of a stall
    set_id(1, 1, 2, 1, 1, 1, 0, 8); tick();
    set_id(1, 8, 0, 1, 0, 1, 1, 8); tick();
    chk("ar_pre_fa", 32'(ForwardA), 32'b10);
    set_id(1, 8, 0, 1, 0, 1, 0, 9); #1;
    chk("ar_pre_stall", 32'(stall), 1);
    reset = 1'b0; #1;
    chk("ar_stall", 32'(stall), 0);
    chk("ar_bubble", 32'(bubble), 0);
    chk("ar_fa", 32'(ForwardA), 0);
    chk("ar_fb", 32'(ForwardB), 0);
    chk("ar_cnt", 32'(stall_cnt), 0);
    tick(); tick();
    reset = 1'b1; #1;
    chk("ar_post_stall", 32'(stall), 0);
    tick();

    // random traffic over a small register pool
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 299) != 0);
      ID_valid    = ($urandom_range(0, 9) != 0);
      ID_rs       = REG_W'($urandom_range(0, 3));
      ID_rt       = REG_W'($urandom_range(0, 3));
      ID_use_rs   = 1'($urandom_range(0, 1));
      ID_use_rt   = 1'($urandom_range(0, 1));
      ID_RegWrite = ($urandom_range(0, 9) < 7);
      ID_MemRead  = ($urandom_range(0, 9) < 3);
      ID_dst      = REG_W'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 9) == 0);
      hold        = ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 1'b1;
    nop();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Scheduler for the EX-stage operand datapath of the 5-stage MIPS pipeline.
- Tracks destination registers of in-flight instructions in shadow EX/MEM/WB slots.
- Drives registered ForwardA/ForwardB (00 = own bus, 01 = MEMWBdata, 10 = EXMEMdata) into the EX operand muxes.
- Detects load-use hazards and issues a one-cycle stall plus bubble; handles branch/jump flush, external hold, and stall statistics.

Parameters:
- REG_W, 5: register address width.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ID_valid  in  1  ID stage holds a real instruction.
- ID_rs  in  REG_W  source register A of the ID instruction.
- ID_rt  in  REG_W  source register B of the ID instruction.
- ID_use_rs  in  1  ID instruction reads rs through the ALU A path (0 for shamt ops).
- ID_use_rt  in  1  ID instruction reads rt through the ALU B path (0 when ALUSrc2 = 1).
- ID_RegWrite  in  1  ID instruction writes a register.
- ID_MemRead  in  1  ID instruction is a load.
- ID_dst  in  REG_W  destination register of the ID instruction.
- flush  in  1  branch/jump taken; kill the ID instruction.
- hold  in  1  global freeze (e.g. memory busy).
- ForwardA  out  2  registered forward select for ALU A.
- ForwardB  out  2  registered forward select for ALU B.
- stall  out  1  combinational; hold PC and IF/ID.
- bubble  out  1  combinational; zero the ID/EX control fields.
- stall_cnt  out  CNT_W  number of load-use stall cycles taken, saturating.

Behaviour:
- Reset (reset = 0, async): all slot valid bits = 0; ForwardA = ForwardB = 00; stall_cnt = 0. stall and bubble then evaluate to 0.
- Slots: EX, MEM and WB each hold {valid, RegWrite, MemRead, dst}. A slot counts as a writer only if valid && RegWrite && dst != 0.
- Load-use hazard: EX slot is a writer with MemRead = 1, and ID_valid && ((ID_use_rs && ID_rs == EX.dst) || (ID_use_rt && ID_rt == EX.dst)).
- stall = hazard && !flush && !hold.
- bubble = (stall || flush) && !hold.
- Forward select for A on the next edge:
  - 10 if ID_use_rs, EX slot is a non-load writer, and EX.dst == ID_rs.
  - else 01 if ID_use_rs, MEM slot is a writer, and MEM.dst == ID_rs.
  - else 00.
  - EX-slot match has priority over MEM-slot match.
  - B is computed identically using ID_use_rt and ID_rt.
- Register 0 is never forwarded and never causes a stall.
- The WB slot is tracking only: the register file is write-before-read, so no forwarding from WB.
- Edge update when hold = 1: every slot, ForwardA/B and stall_cnt keep their values.
- Edge update when hold = 0:
  - WB <= MEM; MEM <= EX.
  - If bubble: EX <= invalid and ForwardA/B <= 00.
  - Otherwise: EX <= ID fields (valid = ID_valid) and ForwardA/B <= the computed selects.
  - stall_cnt increments when stall = 1, saturating at all-ones.
- Latency:
  - A producer issued in cycle n forwards 10 to a dependent instruction issued in n+1.
  - It forwards 01 to a dependent instruction issued in n+2.
  - A load followed immediately by a dependent instruction costs exactly one stall cycle; the consumer then gets 01.
- Simultaneous events:
  - hold overrides everything.
  - flush overrides stall: stall_cnt does not increment and the bubble is inserted.
  - A stalled instruction is re-evaluated every cycle.
- Reset mid-operation clears all slots immediately; there are no pending stalls after release.

Test Plan:
1. Back-to-back dependency: add $3 <- $1,$2 then sub $4 <- $3,$5 (use_rs) -> ForwardA = 10 and ForwardB = 00 in sub's EX cycle; stall never asserted.
2. Distance-2 dependency: add $3, nop, or $6 <- $7,$3 (use_rt) -> ForwardB = 01; and $3 written by both EX and MEM slots -> 10 wins.
3. Load-use: lw $8 then add $9 <- $8,$8 -> stall = bubble = 1 for exactly 1 cycle; next EX cycle has ForwardA = ForwardB = 01; stall_cnt = 1.
4. $0 and unused operands:
   - Writer with dst = 0 followed by a reader of $0 -> Forward = 00, no stall.
   - sll using shamt (use_rs = 0) after a writer of rs -> ForwardA = 00.
5. Flush during load-use: lw $8, add reads $8, flush = 1 the same cycle -> stall = 0, bubble = 1, stall_cnt unchanged.
6. hold and reset:
   - hold = 1 for 3 cycles mid-sequence -> ForwardA/B and stall_cnt frozen, stall = 0; after release, sequencing resumes identically to the unheld run.
   - reset asserted mid-stall -> outputs 00/0 immediately, without waiting for a clock edge.
